// File: rtl/writeback_queue_if.sv
// ============================================================================
// Module      : writeback_queue_if
// Description : Producer handshakes and register-file ports of the writeback
//               queue, plus its hazard status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface writeback_queue_if #(
    parameter int N = 32
);
    logic         a_valid;
    logic         a_ready;
    logic         a_reg_en;
    logic [3:0]   a_addr;
    logic [N-1:0] a_data;
    logic         a_flag_en;
    logic [N-1:0] a_flags;

    logic         b_valid;
    logic         b_ready;
    logic [3:0]   b_addr;
    logic [N-1:0] b_data;

    logic [3:0]   write_address;
    logic [N-1:0] write_data;
    logic         write_enable;
    logic [3:0]   write_address2;
    logic [N-1:0] write_data2;
    logic         write_enable2;
    logic [N-1:0] pc_update;
    logic         pc_write;
    logic [N-1:0] cspr_update;
    logic         cspr_write;
    logic [15:0]  busy_mask;
    logic         empty;

    modport slave (
        input  a_valid, a_reg_en, a_addr, a_data, a_flag_en, a_flags,
        input  b_valid, b_addr, b_data,
        output a_ready, b_ready,
        output write_address, write_data, write_enable,
        output write_address2, write_data2, write_enable2,
        output pc_update, pc_write, cspr_update, cspr_write,
        output busy_mask, empty
    );

    modport master (
        output a_valid, a_reg_en, a_addr, a_data, a_flag_en, a_flags,
        output b_valid, b_addr, b_data,
        input  a_ready, b_ready,
        input  write_address, write_data, write_enable,
        input  write_address2, write_data2, write_enable2,
        input  pc_update, pc_write, cspr_update, cspr_write,
        input  busy_mask, empty
    );
endinterface

`default_nettype wire

// File: rtl/writeback_queue.sv
// ============================================================================
// Module      : writeback_queue
// Description : In-order writeback FIFO fed by ALU (A) and LSU (B); retires up
//               to two entries per cycle onto register file, PC and CSPR ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module writeback_queue #(
    parameter int N     = 32,
    parameter int DEPTH = 4
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    writeback_queue_if.slave wb
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
    localparam logic [3:0]         c_PC_ADDR   = 4'hF;

    logic [c_CNT_W-1:0] r_count;
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;

    logic               r_reg_en  [DEPTH];
    logic [3:0]         r_addr    [DEPTH];
    logic [N-1:0]       r_data    [DEPTH];
    logic               r_flag_en [DEPTH];
    logic [N-1:0]       r_flags   [DEPTH];

    logic [3:0]         r_wr_addr;
    logic [N-1:0]       r_wr_data;
    logic               r_wr_en;
    logic [3:0]         r_wr_addr2;
    logic [N-1:0]       r_wr_data2;
    logic               r_wr_en2;
    logic [N-1:0]       r_pc_data;
    logic               r_pc_wr;
    logic [N-1:0]       r_cs_data;
    logic               r_cs_wr;

    logic [c_CNT_W-1:0] w_free;
    logic               w_a_ready;
    logic               w_b_ready;
    logic               w_a_fire;
    logic               w_a_store;
    logic               w_b_fire;
    logic [c_PTR_W-1:0] w_b_idx;
    logic [c_CNT_W-1:0] w_push_cnt;
    logic [c_PTR_W-1:0] w_s0;
    logic [c_PTR_W-1:0] w_s1;
    logic               w_conflict;
    logic               w_pop0;
    logic               w_pop1;
    logic [c_CNT_W-1:0] w_pop_cnt;
    logic [c_PTR_W-1:0] w_idx;
    logic [15:0]        w_busy;

    // Readiness uses only the registered count; a pop this cycle gives no credit.
    assign w_free     = c_DEPTH_CNT - r_count;
    assign w_a_ready  = (w_free != '0);
    assign w_b_ready  = (w_free >= c_CNT_W'(2)) || ((w_free != '0) && !wb.a_valid);
    assign w_a_fire   = wb.a_valid && w_a_ready;
    assign w_a_store  = w_a_fire && (wb.a_reg_en || wb.a_flag_en);
    assign w_b_fire   = wb.b_valid && w_b_ready;
    assign w_b_idx    = w_a_store ? r_tail + c_PTR_W'(1) : r_tail;
    assign w_push_cnt = c_CNT_W'(w_a_store) + c_CNT_W'(w_b_fire);

    assign w_s0 = r_head;
    assign w_s1 = r_head + c_PTR_W'(1);

    // The second slot may only retire alongside the first if no port collides.
    assign w_conflict = (r_reg_en[w_s0] && r_reg_en[w_s1] && (r_addr[w_s0] == r_addr[w_s1]))
                      || (r_reg_en[w_s0] && r_reg_en[w_s1]
                          && (r_addr[w_s0] == c_PC_ADDR) && (r_addr[w_s1] == c_PC_ADDR))
                      || (r_flag_en[w_s0] && r_flag_en[w_s1]);
    assign w_pop0    = (r_count != '0);
    assign w_pop1    = (r_count >= c_CNT_W'(2)) && !w_conflict;
    assign w_pop_cnt = c_CNT_W'(w_pop0) + c_CNT_W'(w_pop1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            r_count <= r_count - w_pop_cnt + w_push_cnt;
            r_head  <= r_head + c_PTR_W'(w_pop_cnt);
            r_tail  <= r_tail + c_PTR_W'(w_push_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (w_a_store) begin
            r_reg_en[r_tail]  <= wb.a_reg_en;
            r_addr[r_tail]    <= wb.a_addr;
            r_data[r_tail]    <= wb.a_data;
            r_flag_en[r_tail] <= wb.a_flag_en;
            r_flags[r_tail]   <= wb.a_flags;
        end
        if (w_b_fire) begin
            r_reg_en[w_b_idx]  <= 1'b1;
            r_addr[w_b_idx]    <= wb.b_addr;
            r_data[w_b_idx]    <= wb.b_data;
            r_flag_en[w_b_idx] <= 1'b0;
            r_flags[w_b_idx]   <= '0;
        end
    end

    // Enables pulse for one cycle per pop; address/data hold their last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr2 <= '0;
            r_wr_data2 <= '0;
            r_wr_en2   <= 1'b0;
            r_pc_data  <= '0;
            r_pc_wr    <= 1'b0;
            r_cs_data  <= '0;
            r_cs_wr    <= 1'b0;
        end else begin
            r_wr_en  <= 1'b0;
            r_wr_en2 <= 1'b0;
            r_pc_wr  <= 1'b0;
            r_cs_wr  <= 1'b0;
            if (w_pop0) begin
                if (r_reg_en[w_s0]) begin
                    if (r_addr[w_s0] == c_PC_ADDR) begin
                        r_pc_data <= r_data[w_s0];
                        r_pc_wr   <= 1'b1;
                    end else begin
                        r_wr_addr <= r_addr[w_s0];
                        r_wr_data <= r_data[w_s0];
                        r_wr_en   <= 1'b1;
                    end
                end
                if (r_flag_en[w_s0]) begin
                    r_cs_data <= r_flags[w_s0];
                    r_cs_wr   <= 1'b1;
                end
            end
            if (w_pop1) begin
                if (r_reg_en[w_s1]) begin
                    if (r_addr[w_s1] == c_PC_ADDR) begin
                        r_pc_data <= r_data[w_s1];
                        r_pc_wr   <= 1'b1;
                    end else begin
                        r_wr_addr2 <= r_addr[w_s1];
                        r_wr_data2 <= r_data[w_s1];
                        r_wr_en2   <= 1'b1;
                    end
                end
                if (r_flag_en[w_s1]) begin
                    r_cs_data <= r_flags[w_s1];
                    r_cs_wr   <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_busy = '0;
        w_idx  = r_head;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_head + c_PTR_W'(k);
            if ((c_CNT_W'(k) < r_count) && r_reg_en[w_idx]) begin
                w_busy[r_addr[w_idx]] = 1'b1;
            end
        end
        if (r_wr_en) begin
            w_busy[r_wr_addr] = 1'b1;
        end
        if (r_wr_en2) begin
            w_busy[r_wr_addr2] = 1'b1;
        end
        if (r_pc_wr) begin
            w_busy[c_PC_ADDR] = 1'b1;
        end
    end

    assign wb.a_ready        = w_a_ready;
    assign wb.b_ready        = w_b_ready;
    assign wb.write_address  = r_wr_addr;
    assign wb.write_data     = r_wr_data;
    assign wb.write_enable   = r_wr_en;
    assign wb.write_address2 = r_wr_addr2;
    assign wb.write_data2    = r_wr_data2;
    assign wb.write_enable2  = r_wr_en2;
    assign wb.pc_update      = r_pc_data;
    assign wb.pc_write       = r_pc_wr;
    assign wb.cspr_update    = r_cs_data;
    assign wb.cspr_write     = r_cs_wr;
    assign wb.busy_mask      = w_busy;
    assign wb.empty          = (r_count == '0) && !(r_wr_en || r_wr_en2 || r_pc_wr || r_cs_wr);

endmodule

`default_nettype wire

// File: tb/tb_writeback_queue.sv
// ============================================================================
// Module      : tb_writeback_queue
// Description : Self-checking bench: per-register ordered scoreboard of
//               expected writes, checked by an independent negedge monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_writeback_queue;
    localparam int N     = 32;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    writeback_queue_if #(.N(N)) ifc ();

    writeback_queue #(.N(N), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (ifc.slave)
    );

    typedef struct packed {
        logic [3:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         regq[$];
    logic [31:0] csq[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          mon_en  = 1'b0;
    logic        fa, fb;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // A register write must be the oldest outstanding expected write to that register.
    function automatic void check_reg(string port, logic [3:0] a, logic [31:0] d);
        int idx;
        idx = -1;
        for (int i = 0; i < regq.size(); i++) begin
            if (regq[i].a == a) begin
                idx = i;
                break;
            end
        end
        n_tests++;
        if (idx < 0) begin
            n_fail++;
            $display("FAIL %s: unexpected write R%0d=0x%0h, expected none", port, a, d);
        end else begin
            if (regq[idx].d !== d) begin
                n_fail++;
                $display("FAIL %s: R%0d got 0x%0h, expected 0x%0h", port, a, d, regq[idx].d);
            end
            regq.delete(idx);
        end
    endfunction

    initial begin
        logic [15:0] eb;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                eb = '0;
                foreach (regq[i]) eb[regq[i].a] = 1'b1;
                chk("busy_mask", 32'(ifc.busy_mask), 32'(eb));
                chk("empty", 32'(ifc.empty), 32'(regq.size() == 0 && csq.size() == 0));
                if (ifc.write_enable)  check_reg("port1", ifc.write_address, ifc.write_data);
                if (ifc.pc_write)      check_reg("pc", 4'hF, ifc.pc_update);
                if (ifc.write_enable2) check_reg("port2", ifc.write_address2, ifc.write_data2);
                if (ifc.cspr_write) begin
                    n_tests++;
                    if (csq.size() == 0) begin
                        n_fail++;
                        $display("FAIL cspr: unexpected write 0x%0h, expected none", ifc.cspr_update);
                    end else begin
                        if (csq[0] !== ifc.cspr_update) begin
                            n_fail++;
                            $display("FAIL cspr: got 0x%0h, expected 0x%0h", ifc.cspr_update, csq[0]);
                        end
                        void'(csq.pop_front());
                    end
                end
            end
        end
    end

    task automatic drive(input logic av, input logic aen, input logic [3:0] aad,
                         input logic [31:0] ad, input logic afe, input logic [31:0] af,
                         input logic bv, input logic [3:0] bad, input logic [31:0] bd,
                         output logic o_fa, output logic o_fb);
        @(negedge clk);
        #2;
        ifc.a_valid   = av;
        ifc.a_reg_en  = aen;
        ifc.a_addr    = aad;
        ifc.a_data    = ad;
        ifc.a_flag_en = afe;
        ifc.a_flags   = af;
        ifc.b_valid   = bv;
        ifc.b_addr    = bad;
        ifc.b_data    = bd;
        #1;
        o_fa = av && ifc.a_ready;
        o_fb = bv && ifc.b_ready;
        @(posedge clk);
        if (o_fa) begin
            if (aen) regq.push_back(wr_t'{aad, ad});
            if (afe) csq.push_back(af);
        end
        if (o_fb) regq.push_back(wr_t'{bad, bd});
        #1;
        ifc.a_valid = 1'b0;
        ifc.b_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int c;
        c = 0;
        while (!ifc.empty && c < 50) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("drain", 32'(ifc.empty), 32'd1);
    endtask

    task automatic chk_no_enables(string name);
        chk(name, {28'd0, ifc.write_enable, ifc.write_enable2, ifc.pc_write, ifc.cspr_write}, 32'd0);
    endtask

    initial begin
        logic [3:0] addr_tab [4];
        addr_tab[0] = 4'd1; addr_tab[1] = 4'd2; addr_tab[2] = 4'd3; addr_tab[3] = 4'd15;

        ifc.a_valid = 1'b1; ifc.a_reg_en = 1'b1; ifc.a_addr = 4'd3; ifc.a_data = 32'h55;
        ifc.a_flag_en = 1'b0; ifc.a_flags = '0;
        ifc.b_valid = 1'b0; ifc.b_addr = '0; ifc.b_data = '0;

        // Reset held with a valid producer: nothing may be written.
        repeat (3) begin
            @(posedge clk);
            #1;
            chk_no_enables("reset_enables");
            chk("reset_busy", 32'(ifc.busy_mask), 32'd0);
            chk("reset_empty", 32'(ifc.empty), 32'd1);
        end
        @(negedge clk);
        #2;
        ifc.a_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("a_ready_after_reset", 32'(ifc.a_ready), 32'd1);
        mon_en = 1'b1;

        // Dual push to distinct registers retires on both ports in one cycle.
        drive(1, 1, 4'd3, 32'h11, 0, 0, 1, 4'd5, 32'h22, fa, fb);
        chk("dual_busy_queued", 32'(ifc.busy_mask & 16'h0028), 32'h28);
        @(posedge clk); #1;
        chk("dual_p1", {27'd0, ifc.write_enable, ifc.write_address}, {27'd0, 1'b1, 4'd3});
        chk("dual_p1_data", ifc.write_data, 32'h11);
        chk("dual_p2", {27'd0, ifc.write_enable2, ifc.write_address2}, {27'd0, 1'b1, 4'd5});
        chk("dual_p2_data", ifc.write_data2, 32'h22);
        chk("dual_busy_presented", 32'(ifc.busy_mask), 32'h28);
        @(posedge clk); #1;
        chk_no_enables("dual_enables_drop");
        chk("dual_busy_clear", 32'(ifc.busy_mask), 32'd0);

        // Same destination must serialise over two cycles on port 1.
        drive(1, 1, 4'd4, 32'd1, 0, 0, 1, 4'd4, 32'd2, fa, fb);
        @(posedge clk); #1;
        chk("samedst_c1", {ifc.write_data[26:0], ifc.write_enable, ifc.write_address},
            {27'd1, 1'b1, 4'd4});
        chk("samedst_c1_p2", 32'(ifc.write_enable2), 32'd0);
        @(posedge clk); #1;
        chk("samedst_c2", {ifc.write_data[26:0], ifc.write_enable, ifc.write_address},
            {27'd2, 1'b1, 4'd4});
        wait_empty();

        // PC plus flags from one A entry.
        drive(1, 1, 4'd15, 32'h100, 1, 32'hF000_0000, 0, 0, 0, fa, fb);
        @(posedge clk); #1;
        chk("pc_write", 32'(ifc.pc_write), 32'd1);
        chk("pc_update", ifc.pc_update, 32'h100);
        chk("cspr_write", 32'(ifc.cspr_write), 32'd1);
        chk("cspr_update", ifc.cspr_update, 32'hF000_0000);
        chk("pc_no_port1", 32'(ifc.write_enable), 32'd0);
        wait_empty();

        // Back-pressure: a conflict chain on R7 keeps the queue near full.
        drive(1, 1, 4'd7, 32'd1, 0, 0, 1, 4'd7, 32'd2, fa, fb);
        chk("bp_c1", {30'd0, fa, fb}, 32'd3);
        drive(1, 1, 4'd7, 32'd3, 0, 0, 1, 4'd7, 32'd4, fa, fb);
        chk("bp_c2", {30'd0, fa, fb}, 32'd3);
        drive(1, 1, 4'd7, 32'd5, 0, 0, 1, 4'd7, 32'd6, fa, fb);
        chk("bp_c3_b_blocked", {30'd0, fa, fb}, 32'd2);
        drive(0, 0, 4'd0, 32'd0, 0, 0, 1, 4'd7, 32'd7, fa, fb);
        chk("bp_c4_b_alone", 32'(fb), 32'd1);
        wait_empty();

        // Wrap-around: alternating single and dual pushes.
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 4'($urandom_range(0, 15)), $urandom, 0, 0,
                  logic'(i % 2), 4'($urandom_range(0, 14)), $urandom, fa, fb);
        end
        wait_empty();

        // Reset mid-burst discards queued entries without any write.
        drive(1, 1, 4'd1, 32'hA1, 0, 0, 1, 4'd2, 32'hA2, fa, fb);
        drive(1, 1, 4'd3, 32'hA3, 0, 0, 1, 4'd3, 32'hA4, fa, fb);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        regq.delete();
        csq.delete();
        #1;
        chk_no_enables("midreset_enables");
        chk("midreset_empty", 32'(ifc.empty), 32'd1);
        chk("midreset_busy", 32'(ifc.busy_mask), 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk_no_enables("postreset_no_pulse");
        end

        // Randomised traffic with frequent conflicts, PC writes and flag updates.
        for (int i = 0; i < 300; i++) begin
            drive(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 3) != 0),
                  addr_tab[$urandom_range(0, 3)], $urandom,
                  logic'($urandom_range(0, 2) == 0), $urandom,
                  logic'($urandom_range(0, 1)), addr_tab[$urandom_range(0, 3)], $urandom,
                  fa, fb);
        end
        wait_empty();
        @(negedge clk);
        #1;
        chk("nothing_lost", 32'(regq.size() + csq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
